// File: rtl/serial_clock_gen_if.sv
// Serial clock generator control/status bundle: run control and configuration in,
// generated sclk, edge strobes and frame tracking out.
interface serial_clock_gen_if #(
  parameter int DIV_WIDTH = 16,
  parameter int BIT_WIDTH = 3
);
  logic                 enable;
  logic [DIV_WIDTH-1:0] div;
  logic                 cpol;
  logic [BIT_WIDTH-1:0] frame_len;
  logic                 sclk;
  logic                 sclk_pos_edge;
  logic                 sclk_neg_edge;
  logic                 frame_start;
  logic                 frame_end;
  logic [BIT_WIDTH-1:0] bit_idx;
  logic                 busy;

  modport master (
    output enable, div, cpol, frame_len,
    input  sclk, sclk_pos_edge, sclk_neg_edge, frame_start, frame_end, bit_idx, busy
  );

  modport slave (
    input  enable, div, cpol, frame_len,
    output sclk, sclk_pos_edge, sclk_neg_edge, frame_start, frame_end, bit_idx, busy
  );
endinterface

// File: rtl/serial_clock_gen.sv
// Programmable serial clock generator: sclk = clk / (2*(div+1)), registered edge strobes
// and frame/bit tracking. Config is shadowed while idle and frozen while running.
module serial_clock_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int BIT_WIDTH = 3
) (
  input logic              clk,
  input logic              rst_n,
  serial_clock_gen_if.slave bus
);
  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 cpol_q;
  logic [BIT_WIDTH-1:0] flen_q;
  logic [BIT_WIDTH-1:0] bit_idx;
  logic                 sclk;
  logic                 pos_edge;
  logic                 neg_edge;
  logic                 frame_start;
  logic                 frame_end;
  logic                 busy;
  logic                 leading;

  // A toggle is leading when the new level moves away from the idle polarity.
  assign leading = (~sclk) != cpol_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      flen_q      <= '0;
      bit_idx     <= '0;
      sclk        <= 1'b0;
      pos_edge    <= 1'b0;
      neg_edge    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pos_edge    <= 1'b0;
      neg_edge    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      if (!bus.enable) begin
        // Idle also covers an abort: force idle values without any strobe.
        div_q   <= bus.div;
        cpol_q  <= bus.cpol;
        flen_q  <= bus.frame_len;
        sclk    <= bus.cpol;
        count   <= '0;
        bit_idx <= '0;
        busy    <= 1'b0;
      end else begin
        busy <= 1'b1;
        if (count == div_q) begin
          count    <= '0;
          sclk     <= ~sclk;
          pos_edge <= ~sclk;
          neg_edge <= sclk;
          if (leading) begin
            frame_start <= (bit_idx == '0);
          end else if (bit_idx == flen_q) begin
            frame_end <= 1'b1;
            bit_idx   <= '0;
          end else begin
            bit_idx <= bit_idx + BIT_WIDTH'(1);
          end
        end else begin
          count <= count + DIV_WIDTH'(1);
        end
      end
    end
  end

  assign bus.sclk          = sclk;
  assign bus.sclk_pos_edge = pos_edge;
  assign bus.sclk_neg_edge = neg_edge;
  assign bus.frame_start   = frame_start;
  assign bus.frame_end     = frame_end;
  assign bus.bit_idx       = bit_idx;
  assign bus.busy          = busy;
endmodule

// File: doc/serial_clock_gen.md
Name: serial_clock_gen

Overview:
- Programmable serial-clock generator: derives sclk from clk by a runtime divisor.
- Single-cycle strobes on every sclk rising and falling edge.
- Frame tracking for serial words of configurable length: bit index, frame-start and frame-end strobes.
- Feeds the shift-register and serial-link logic; adds runtime divide, idle polarity, enable/stop control and async reset.

Parameters:
- DIV_WIDTH, 16, width of the half-period divisor.
- BIT_WIDTH, 3, width of the bit index; max frame length is 2**BIT_WIDTH bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- enable  in  1  run request; high = generate sclk, low = return to idle.
- div  in  DIV_WIDTH  half-period minus 1, in clk cycles.
- cpol  in  1  idle level of sclk.
- frame_len  in  BIT_WIDTH  bits per frame minus 1.
- sclk  out  1  generated serial clock, registered.
- sclk_pos_edge  out  1  one-cycle strobe: sclk went 0->1 this cycle.
- sclk_neg_edge  out  1  one-cycle strobe: sclk went 1->0 this cycle.
- frame_start  out  1  one-cycle strobe on the leading edge of bit 0.
- frame_end  out  1  one-cycle strobe on the trailing edge of the last bit.
- bit_idx  out  BIT_WIDTH  index of the bit currently in flight.
- busy  out  1  high while running.

Behaviour:
- Reset (rst_n low, async): count=0, bit_idx=0, busy=0, all strobes=0, shadow div=0, shadow cpol=0, sclk=0.
- After reset release, sclk follows the cpol shadow.
- Idle (enable low):
  - shadow div, shadow cpol and shadow frame_len reload every cycle.
  - sclk=cpol shadow; count=0; bit_idx=0; busy=0; no strobes.
- Run (enable high):
  - Shadows frozen; input changes are ignored until the next idle cycle.
  - busy=1 from the first enabled edge.
  - Each edge: if count==div, then toggle sclk and set count=0; else count=count+1.
- Timing:
  - First toggle occurs on the (div+1)th enabled clk edge.
  - sclk period = 2*(div+1) clk cycles; div=0 gives clk/2.
- Strobes:
  - Registered; high for exactly one cycle, the cycle in which the new sclk value is visible.
  - sclk_pos_edge/sclk_neg_edge reflect the actual direction of the toggle.
- Leading vs trailing edge:
  - Leading edge = transition away from cpol; trailing edge = transition back to cpol.
- Frame tracking:
  - frame_start=1 with the leading-edge strobe when bit_idx==0.
  - On a trailing edge: if bit_idx==frame_len, then frame_end=1 and bit_idx=0; else bit_idx=bit_idx+1.
  - frame_len=0 gives frame_start and frame_end every sclk period.
- Stop:
  - enable falling mid-frame aborts immediately: next edge forces idle values.
  - No strobe is generated for a forced return, even if sclk changes level.
  - Restarting begins a fresh frame at bit 0.
- Simultaneous events:
  - enable falling on the same edge as count==div → idle wins; no toggle, no strobe.
  - rst_n overrides everything at any time.
- Arithmetic:
  - count is DIV_WIDTH bits and never exceeds the shadow div; no overflow path.
  - div=all-ones is legal: half-period 2**DIV_WIDTH cycles.

Test Plan:
- Reset mid-run: pulse rst_n low with enable=1, div=3 → outputs zero immediately (async); after release with enable=0, cpol=1 → sclk=1 next edge, no strobes.
- div=3, cpol=0, enable rises at edge 0 → sclk rises at edge 4 with sclk_pos_edge=1 for that cycle only; falls at edge 8 with sclk_neg_edge; period 8 cycles over 10 periods.
- div=0, cpol=1, frame_len=7 → sclk toggles every cycle. sclk_neg_edge is leading: frame_start on 1st leading edge; bit_idx 0..7; frame_end on 8th trailing (rising) edge; pattern repeats every 16 cycles.
- Change div from 3 to 9 while enable=1 → period stays 8 until enable drops for ≥1 cycle and rises again, then period 20.
- enable dropped after bit_idx reaches 2 (frame_len=7), while sclk is high (cpol=0) → next edge: sclk=0, bit_idx=0, busy=0, no sclk_neg_edge, no frame_end; re-enable → frame_start on the next leading edge.
- div=1, enable falls on the edge where count==1 → no toggle, no strobe; sclk stays at cpol.
